mem_rd_delay_cal: RTL and testbench

Read-capture phase calibration controller for the memory PHY. It owns the 4-bit PLL dynamic-delay code that steers the read-capture clock. On request it sweeps all 16 codes. For each code it waits for PLL re-lock/settle, runs one memory test pass through a request/ack handshake, and records pass/fail. It then programs the centre of the widest passing window. It sits between the system manager's delay input and the memory test/controller core, and also supports a manual override for debug.

---
 rtl/mem_rd_delay_cal.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_rd_delay_cal.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_delay_cal.sv
// Read-capture phase calibration: sweeps the 4-bit PLL delay code, tests each code,
// then programs the floor centre of the widest passing window (manual override when idle).
module mem_rd_delay_cal #(
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned DEFAULT_DELAY  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cal_start,
  input  logic        man_wr,
  input  logic [3:0]  man_delay,
  output logic [3:0]  delay,
  output logic        test_go,
  input  logic        test_done,
  input  logic        test_ok,
  output logic        busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [15:0] pass_map,
  output logic [3:0]  win_start,
  output logic [4:0]  win_len
);

  // state    | meaning
  // S_IDLE   | waiting for cal_start, accepts manual delay writes
  // S_SET    | drive the current sweep code onto delay
  // S_SETTLE | wait for PLL re-lock / FIFO flush
  // S_TEST   | one-cycle test_go request
  // S_WAIT   | wait for test_done or timeout
  // S_NEXT   | update run trackers, advance code
  // S_PICK   | latch best window and target code
  // S_APPLY  | drive target code and let it settle
  // S_DONE   | pulse cal_done, drop busy
  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_SETTLE, S_TEST, S_WAIT, S_NEXT, S_PICK, S_APPLY, S_DONE
  } state_t;

  localparam logic [3:0]  DEF_CODE  = 4'(DEFAULT_DELAY);
  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES);
  localparam logic [31:0] TMO_LD    = 32'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  delay_q, delay_d;
  logic        busy_q, busy_d;
  logic        cal_fail_q, cal_fail_d;
  logic [15:0] pass_map_q, pass_map_d;
  logic [3:0]  win_start_q, win_start_d;
  logic [4:0]  win_len_q, win_len_d;
  logic [3:0]  run_start_q, run_start_d;
  logic [4:0]  run_len_q, run_len_d;
  logic [3:0]  best_start_q, best_start_d;
  logic [4:0]  best_len_q, best_len_d;
  logic [3:0]  target_q, target_d;

  logic [4:0]  run_len_inc;
  logic [3:0]  run_start_new;
  logic [4:0]  half_len;

  // Down-counter terminal count; a load of 0 still yields one cycle in the state.
  logic        cnt_tc;
  assign cnt_tc = (cnt_q <= 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= 4'd0;
      cnt_q        <= 32'd0;
      delay_q      <= DEF_CODE;
      busy_q       <= 1'b0;
      cal_fail_q   <= 1'b0;
      pass_map_q   <= 16'd0;
      win_start_q  <= 4'd0;
      win_len_q    <= 5'd0;
      run_start_q  <= 4'd0;
      run_len_q    <= 5'd0;
      best_start_q <= 4'd0;
      best_len_q   <= 5'd0;
      target_q     <= DEF_CODE;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      delay_q      <= delay_d;
      busy_q       <= busy_d;
      cal_fail_q   <= cal_fail_d;
      pass_map_q   <= pass_map_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      target_q     <= target_d;
    end
  end

  always_comb begin
    run_len_inc   = run_len_q + 5'd1;
    run_start_new = (run_len_q == 5'd0) ? code_q : run_start_q;
    half_len      = (best_len_q - 5'd1) >> 1;
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    delay_d      = delay_q;
    busy_d       = busy_q;
    cal_fail_d   = cal_fail_q;
    pass_map_d   = pass_map_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    target_d     = target_q;

    case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          busy_d       = 1'b1;
          code_d       = 4'd0;
          pass_map_d   = 16'd0;
          run_start_d  = 4'd0;
          run_len_d    = 5'd0;
          best_start_d = 4'd0;
          best_len_d   = 5'd0;
          state_d      = S_SET;
        end else if (man_wr) begin
          delay_d = man_delay;
        end
      end
      S_SET: begin
        delay_d = code_q;
        cnt_d   = SETTLE_LD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_tc) begin
          cnt_d   = 32'd0;
          state_d = S_TEST;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_TEST: begin
        cnt_d   = TMO_LD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // test_done has priority over a simultaneous timeout.
        if (test_done) begin
          pass_map_d[code_q] = test_ok;
          cnt_d              = 32'd0;
          state_d            = S_NEXT;
        end else if (cnt_tc) begin
          pass_map_d[code_q] = 1'b0;
          cnt_d              = 32'd0;
          state_d            = S_NEXT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_NEXT: begin
        if (pass_map_q[code_q]) begin
          run_len_d   = run_len_inc;
          run_start_d = run_start_new;
          // Strictly longer only, so ties keep the lowest start.
          if (run_len_inc > best_len_q) begin
            best_len_d   = run_len_inc;
            best_start_d = run_start_new;
          end
        end else begin
          run_len_d = 5'd0;
        end
        if (code_q == 4'd15) begin
          state_d = S_PICK;
        end else begin
          code_d  = code_q + 4'd1;
          state_d = S_SET;
        end
      end
      S_PICK: begin
        win_start_d = best_start_q;
        win_len_d   = best_len_q;
        if (best_len_q == 5'd0) begin
          cal_fail_d = 1'b1;
          target_d   = DEF_CODE;
        end else begin
          cal_fail_d = 1'b0;
          target_d   = best_start_q + half_len[3:0];
        end
        cnt_d   = SETTLE_LD;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        delay_d = target_q;
        if (cnt_tc) begin
          cnt_d   = 32'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign delay     = delay_q;
  assign test_go   = (state_q == S_TEST);
  assign cal_done  = (state_q == S_DONE);
  assign busy      = busy_q;
  assign cal_fail  = cal_fail_q;
  assign pass_map  = pass_map_q;
  assign win_start = win_start_q;
  assign win_len   = win_len_q;

endmodule

// File: tb/tb_mem_rd_delay_cal.sv
// Directed bench for mem_rd_delay_cal: a behavioural test responder answers test_go
// from a per-code pass pattern; results are compared against hand-computed values.
module tb_mem_rd_delay_cal;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cal_start = 1'b0;
  logic        man_wr = 1'b0;
  logic [3:0]  man_delay = 4'd0;
  logic [3:0]  delay;
  logic        test_go;
  logic        test_done = 1'b0;
  logic        test_ok = 1'b0;
  logic        busy;
  logic        cal_done;
  logic        cal_fail;
  logic [15:0] pass_map;
  logic [3:0]  win_start;
  logic [4:0]  win_len;

  logic [15:0] pattern = 16'h0000;
  logic [15:0] silent  = 16'h0000;
  int          go_cnt = 0;
  int          done_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  int          go_snap, done_snap;
  bit          seen;

  mem_rd_delay_cal #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(16),
    .DEFAULT_DELAY (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cal_start(cal_start),
    .man_wr   (man_wr),
    .man_delay(man_delay),
    .delay    (delay),
    .test_go  (test_go),
    .test_done(test_done),
    .test_ok  (test_ok),
    .busy     (busy),
    .cal_done (cal_done),
    .cal_fail (cal_fail),
    .pass_map (pass_map),
    .win_start(win_start),
    .win_len  (win_len)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (test_go) go_cnt++;
      if (cal_done) done_cnt++;
    end
  end

  // Test responder: answers after two cycles; silent codes answer only after the timeout.
  initial begin
    logic [3:0] c;
    forever begin
      @(negedge clk);
      if (test_go) begin
        c = delay;
        if (silent[c]) begin
          repeat (20) @(negedge clk);
          test_ok = 1'b1;
        end else begin
          repeat (2) @(negedge clk);
          test_ok = pattern[c];
        end
        test_done = 1'b1;
        @(negedge clk);
        test_done = 1'b0;
        test_ok   = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic pulse_man(input logic [3:0] v);
    @(negedge clk);
    man_wr    = 1'b1;
    man_delay = v;
    @(negedge clk);
    man_wr = 1'b0;
  endtask

  task automatic wait_cal_done(input string tag);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (cal_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_delay(input logic [3:0] v, input string tag);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (delay == v) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic run_sweep(input logic [15:0] pat, input logic [15:0] sil, input string tag);
    pattern   = pat;
    silent    = sil;
    go_snap   = go_cnt;
    done_snap = done_cnt;
    pulse_start();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_cal_done(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_delay", 32'(delay), 32'd8);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_test_go", 32'(test_go), 32'd0);
    check("rst_cal_done", 32'(cal_done), 32'd0);
    check("rst_cal_fail", 32'(cal_fail), 32'd0);
    check("rst_pass_map", 32'(pass_map), 32'd0);
    check("rst_win_start", 32'(win_start), 32'd0);
    check("rst_win_len", 32'(win_len), 32'd0);

    pulse_man(4'd3);
    check("man_idle_delay", 32'(delay), 32'd3);

    run_sweep(16'hFFFF, 16'h0000, "all");
    check("all_pass_map", 32'(pass_map), 32'hFFFF);
    check("all_win_start", 32'(win_start), 32'd0);
    check("all_win_len", 32'(win_len), 32'd16);
    check("all_delay", 32'(delay), 32'd7);
    check("all_cal_fail", 32'(cal_fail), 32'd0);
    check("all_go_count", 32'(go_cnt - go_snap), 32'd16);
    check("all_done_count", 32'(done_cnt - done_snap), 32'd1);
    check("all_busy_after", 32'(busy), 32'd0);

    run_sweep(16'h03F0, 16'h0000, "mid");
    check("mid_pass_map", 32'(pass_map), 32'h03F0);
    check("mid_win_start", 32'(win_start), 32'd4);
    check("mid_win_len", 32'(win_len), 32'd6);
    check("mid_delay", 32'(delay), 32'd6);

    run_sweep(16'h1C1C, 16'h0000, "tie");
    check("tie_pass_map", 32'(pass_map), 32'h1C1C);
    check("tie_win_start", 32'(win_start), 32'd2);
    check("tie_win_len", 32'(win_len), 32'd3);
    check("tie_delay", 32'(delay), 32'd3);

    run_sweep(16'h0000, 16'h0000, "none");
    check("none_pass_map", 32'(pass_map), 32'h0000);
    check("none_cal_fail", 32'(cal_fail), 32'd1);
    check("none_win_len", 32'(win_len), 32'd0);
    check("none_delay", 32'(delay), 32'd8);
    check("none_done_count", 32'(done_cnt - done_snap), 32'd1);

    run_sweep(16'hFFFF, 16'h0020, "tmo");
    check("tmo_pass_map", 32'(pass_map), 32'hFFDF);
    check("tmo_win_start", 32'(win_start), 32'd6);
    check("tmo_win_len", 32'(win_len), 32'd10);
    check("tmo_delay", 32'(delay), 32'd10);
    check("tmo_cal_fail", 32'(cal_fail), 32'd0);
    check("tmo_go_count", 32'(go_cnt - go_snap), 32'd16);

    // Held results survive idle time.
    repeat (10) @(negedge clk);
    check("hold_pass_map", 32'(pass_map), 32'hFFDF);
    check("hold_delay", 32'(delay), 32'd10);

    pattern   = 16'hFFFF;
    silent    = 16'h0000;
    done_snap = done_cnt;
    pulse_start();
    wait_delay(4'd2, "busy_wait_code2");
    @(negedge clk);
    man_wr    = 1'b1;
    man_delay = 4'd3;
    @(negedge clk);
    man_wr = 1'b0;
    check("man_busy_ignored", 32'(delay), 32'd2);
    wait_delay(4'd9, "busy_wait_code9");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_delay", 32'(delay), 32'd8);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pass_map", 32'(pass_map), 32'd0);
    repeat (300) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - done_snap), 32'd0);
    check("abort_delay_hold", 32'(delay), 32'd8);

    pulse_man(4'd3);
    check("man_after_abort", 32'(delay), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
